// File: rtl/data_mem_stage_pkg.sv
// Shared MIPS definitions for the M-stage data memory: opcodes, exception codes,
// clearing-FSM state encoding and opcode classification helpers.
package mips_defs;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dm_state_e;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Byte-lane steering for loads/stores: byte enables, replicated store data,
// load extract/extend and natural-alignment check. Purely combinational.
module dm_lane_ctrl
    import mips_defs::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_dat_in,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_dat_out,
    output logic [31:0] ld_dat,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Lanes are picked from the naturally aligned address; misalignment is
    // reported separately from the raw low bits.
    always_comb begin
        ld_byte = rd_word[8*addr_lo +: 8];
        ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        byte_en    = 4'b0000;
        wr_dat_out = wr_dat_in;
        ld_dat     = 32'h0;
        misalign   = 1'b0;
        case (op)
            OP_LW: begin
                ld_dat   = rd_word;
                misalign = (addr_lo != 2'b00);
            end
            OP_SW: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            OP_LH: begin
                ld_dat   = {{16{ld_half[15]}}, ld_half};
                misalign = addr_lo[0];
            end
            OP_LHU: begin
                ld_dat   = {16'h0, ld_half};
                misalign = addr_lo[0];
            end
            OP_SH: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_dat_out = {2{wr_dat_in[15:0]}};
                misalign   = addr_lo[0];
            end
            OP_LB:  ld_dat = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: ld_dat = {24'h0, ld_byte};
            OP_SB: begin
                byte_en    = 4'b0001 << addr_lo;
                wr_dat_out = {4{wr_dat_in[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// M-stage data memory: async read, byte-lane stores, post-reset zeroing (BusyM).
// Define DM_UNALIGNED_TRAP_EN to raise AdEL/AdES on misaligned/out-of-range access.
module data_mem_stage
    import mips_defs::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrM,
    input  logic [31:0] ALURstM,
    input  logic [31:0] WDM,
    input  logic        KillM,
    output logic [31:0] RDM,
    output logic        ExcM,
    output logic [4:0]  ExcCodeM,
    output logic [31:0] BadVAddrM,
    output logic        BusyM
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dm_state_e   state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [5:0]  opcode;
    logic        is_load, is_store;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0] rd_word;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdat;
    logic [31:0] lane_ld;
    logic        lane_misalign;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_dat;

    logic unused_instr;
    assign unused_instr = ^InstrM[25:0];

    assign opcode   = InstrM[31:26];
    assign is_load  = op_is_load(opcode);
    assign is_store = op_is_store(opcode);
    assign offset   = ALURstM - BASE_ADDR;
    assign in_range = ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
    assign mem_idx  = offset[AW+1:2];
    assign rd_word  = mem_q[mem_idx];

    dm_lane_ctrl u_lane (
        .op         (opcode),
        .addr_lo    (ALURstM[1:0]),
        .wr_dat_in  (WDM),
        .rd_word    (rd_word),
        .byte_en    (lane_be),
        .wr_dat_out (lane_wdat),
        .ld_dat     (lane_ld),
        .misalign   (lane_misalign)
    );

    // Clearing FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clearing FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Clearing FSM: outputs
    always_comb begin
        BusyM = (state_q == ST_CLEAR);
    end

    // While clearing, the write port belongs to the sweep and the M-stage
    // instruction is ignored entirely (the hazard unit holds it).
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = mem_idx;
        wr_be     = lane_be;
        wr_dat    = lane_wdat;
        RDM       = 32'h0;
        ExcM      = 1'b0;
        ExcCodeM  = 5'd0;
        BadVAddrM = 32'h0;
        if (BusyM) begin
            wr_en  = 1'b1;
            wr_idx = clr_cnt_q;
            wr_be  = 4'b1111;
            wr_dat = 32'h0;
        end else begin
`ifdef DM_UNALIGNED_TRAP_EN
            if ((is_load || is_store) && (lane_misalign || !in_range)) begin
                ExcM      = 1'b1;
                ExcCodeM  = is_load ? EXC_ADEL : EXC_ADES;
                BadVAddrM = ALURstM;
            end
`endif
            if (is_load && in_range && !ExcM) begin
                RDM = lane_ld;
            end
            if (is_store && in_range && !ExcM && !KillM) begin
                wr_en = 1'b1;
            end
        end
    end

`ifndef DM_UNALIGNED_TRAP_EN
    logic unused_misalign;
    assign unused_misalign = lane_misalign;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage (DEPTH_WORDS = 16) with an expected-result queue;
// expectations follow DM_UNALIGNED_TRAP_EN when it is defined for the build.
module tb_data_mem_stage;

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;
    localparam logic [5:0] ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrM, ALURstM, WDM;
    logic        KillM;
    logic [31:0] RDM, BadVAddrM;
    logic        ExcM, BusyM;
    logic [4:0]  ExcCodeM;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rd;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];

    data_mem_stage #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .InstrM    (InstrM),
        .ALURstM   (ALURstM),
        .WDM       (WDM),
        .KillM     (KillM),
        .RDM       (RDM),
        .ExcM      (ExcM),
        .ExcCodeM  (ExcCodeM),
        .BadVAddrM (BadVAddrM),
        .BusyM     (BusyM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one M-stage instruction, queue its expected outputs, check them
    // mid-cycle, then let the rising edge commit any store.
    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic kill,
                        input logic [31:0] e_rd, input logic e_exc,
                        input logic [4:0] e_code, input logic [31:0] e_bad);
        exp_t e, got;
        @(negedge clk);
        InstrM  = {op, 26'h0};
        ALURstM = addr;
        WDM     = wd;
        KillM   = kill;
        e.rd = e_rd; e.exc = e_exc; e.code = e_code; e.bad = e_bad;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".rd"},   RDM,                 got.rd);
            chk({tag, ".exc"},  {31'h0, ExcM},       {31'h0, got.exc});
            chk({tag, ".code"}, {27'h0, ExcCodeM},   {27'h0, got.code});
            chk({tag, ".bad"},  BadVAddrM,           got.bad);
        end
        @(posedge clk);
    endtask

    task automatic ld(input string tag, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] e_rd);
        step(tag, op, addr, 32'h0, 1'b0, e_rd, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic st(input string tag, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic kill);
        step(tag, op, addr, wd, kill, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Counts rising edges until BusyM drops, starting right after reset release.
    task automatic count_busy(input string tag, input int expected);
        int n = 0;
        while (BusyM && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, expected);
    endtask

    initial begin
        reset   = 1'b1;
        InstrM  = 32'h0;
        ALURstM = 32'h0;
        WDM     = 32'h0;
        KillM   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'h0, BusyM}, 32'h1);
        chk("rst_rdm",  RDM, 32'h0);
        chk("rst_exc",  {31'h0, ExcM}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        count_busy("clear_len", 16);

        for (int w = 0; w < 16; w++) ld($sformatf("zero%0d", w), LW, 32'(w * 4), 32'h0);

        st("sw10", SW, 32'h10, 32'hDEADBEEF, 1'b0);
        st("sb11", SB, 32'h11, 32'h0000_0055, 1'b0);
        ld("lw10",  LW,  32'h10, 32'hDEAD55EF);
        ld("lb13",  LB,  32'h13, 32'hFFFFFFDE);
        ld("lbu13", LBU, 32'h13, 32'h000000DE);
        ld("lb10",  LB,  32'h10, 32'hFFFFFFEF);
        ld("nonmem", ADDI, 32'h10, 32'h0);

        st("sw20", SW, 32'h20, 32'h1234_5678, 1'b0);
        st("sh22", SH, 32'h22, 32'hFFFF_8001, 1'b0);
        ld("lh22",  LH,  32'h22, 32'hFFFF8001);
        ld("lhu22", LHU, 32'h22, 32'h00008001);
        ld("lh20",  LH,  32'h20, 32'h00005678);
        ld("lw20",  LW,  32'h20, 32'h8001_5678);

        st("sw30",      SW, 32'h30, 32'hCAFEF00D, 1'b0);
        st("sw30_kill", SW, 32'h30, 32'h1111_1111, 1'b1);
        ld("lw30",      LW, 32'h30, 32'hCAFEF00D);

        st("sw04", SW, 32'h4, 32'hA5A5_0004, 1'b0);
`ifdef DM_UNALIGNED_TRAP_EN
        step("lw06", LW, 32'h6, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 32'h6);
        step("sw07", SW, 32'h7, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 5'd5, 32'h7);
        ld("lw04_after", LW, 32'h4, 32'hA5A5_0004);
        step("lh21", LH, 32'h21, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 32'h21);
        step("lw40", LW, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 32'h40);
        step("sw40", SW, 32'h40, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 5'd5, 32'h40);
`else
        ld("lw06", LW, 32'h6, 32'hA5A5_0004);
        st("sw07", SW, 32'h7, 32'hFFFF_FFFF, 1'b0);
        ld("lw04_after", LW, 32'h4, 32'hFFFF_FFFF);
        ld("lh21", LH, 32'h21, 32'h00005678);
        ld("lw40", LW, 32'h40, 32'h0);
        st("sw40", SW, 32'h40, 32'hFFFF_FFFF, 1'b0);
`endif
        ld("lw00_noalias", LW, 32'h0, 32'h0);

        // Reset pulse in the middle of the clearing sweep
        @(negedge clk);
        reset   = 1'b1;
        InstrM  = {LW, 26'h0};
        ALURstM = 32'h10;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_busy", {31'h0, BusyM}, 32'h1);
        chk("mid_rdm",  RDM, 32'h0);
        reset   = 1'b1;
        InstrM  = {SW, 26'h0};
        ALURstM = 32'h0;
        WDM     = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0;
        count_busy("restart_len", 16);
        InstrM = 32'h0;
        ld("lw00_clr", LW, 32'h0,  32'h0);
        ld("lw10_clr", LW, 32'h10, 32'h0);
        ld("lw30_clr", LW, 32'h30, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- M-stage data memory with load/store byte-lane handling and address-error detection.
- Consumes InstrM, ALURstM (effective address) and the store data forwarded into M.
- Produces RDM, the extended load data, which the M/W pipeline register latches on the next clock edge.
- Runs a post-reset clearing sequence. It holds the pipeline via BusyM until the memory is zeroed.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- InstrM  input  32  instruction in M; decoded on opcode [31:26]
- ALURstM  input  32  effective byte address
- WDM  input  32  store data, already forwarded
- KillM  input  1  CP0 is flushing the instruction in M; suppresses its store
- RDM  output  32  extended load data, combinational, valid same cycle
- ExcM  output  1  address-error exception raised by this instruction
- ExcCodeM  output  5  4 = AdEL, 5 = AdES, otherwise 0
- BadVAddrM  output  32  faulting address; equals ALURstM when ExcM = 1, else 0
- BusyM  output  1  clearing in progress; the hazard unit stalls F/D/E/M

Behaviour:
- Opcodes:
  - lw = 100011, lb = 100000, lbu = 100100, lh = 100001, lhu = 100101
  - sw = 101011, sb = 101000, sh = 101001
  - All other opcodes perform no memory access.
- Index: idx = (ALURstM − BASE_ADDR) >> 2. The address is in range iff idx < DEPTH_WORDS.
- Read path:
  - Asynchronous read; zero-cycle latency.
  - Little-endian lane selection: byte k = bits [8k+7:8k]; halfword selected by ALURstM[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Non-load instructions, and out-of-range loads, give RDM = 0.
- Write path:
  - Store commits at posedge clk.
  - sw writes all 4 byte enables.
  - sh writes lanes {1,0} or {3,2} from WDM[15:0].
  - sb writes lane ALURstM[1:0] from WDM[7:0].
  - Unselected lanes are untouched.
- A store is suppressed when any of these holds: KillM = 1, ExcM = 1, out of range, or BusyM = 1.
- Load and store to the same word in the same cycle cannot occur (one instruction in M per cycle). A load in the cycle after a store returns the new data.
- FSM states: CLEAR, RUN.
  - reset asserted (asynchronous): state = CLEAR, clr_cnt = 0.
  - CLEAR, each clock edge: mem[clr_cnt] <= 0 and clr_cnt++. When clr_cnt = DEPTH_WORDS−1, that word is written and the next state is RUN.
  - CLEAR therefore lasts exactly DEPTH_WORDS cycles after reset deasserts.
  - RUN: normal operation; it is left only by reset.
  - Reset asserted mid-CLEAR restarts the sequence from word 0.
- Outputs during reset and CLEAR: BusyM = 1, RDM = 0, ExcM = 0, ExcCodeM = 0, BadVAddrM = 0.
- Out-of-range access: no exception and no side effect, unless the trap macro below is enabled.

Optional Feature:
- Macro: DM_UNALIGNED_TRAP_EN.
- Defined:
  - lw/sw with ALURstM[1:0] ≠ 0, or lh/lhu/sh with ALURstM[0] = 1, raise ExcM = 1.
  - An out-of-range access also raises ExcM = 1.
  - Loads report ExcCodeM = 4; stores report 5, and the store is suppressed. BadVAddrM = ALURstM and RDM = 0.
- Undefined:
  - Exception outputs are tied to 0.
  - Low address bits are masked to natural alignment (word: [1:0] = 0; half: [0] = 0) before lane selection.
  - Out-of-range accesses are silently dropped.

Decomposition:
- Shared package (mips_defs):
  - opcode constants OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH
  - ExcCode constants EXC_ADEL = 4, EXC_ADES = 5
  - FSM state encoding for CLEAR and RUN
- One sub-module, dm_lane_ctrl, purely combinational:
  - Inputs: opcode and ALURstM[1:0].
  - Outputs: 4-bit byte enable, aligned write data, load extract/extend of the read word, misalignment flag.

Test Plan:
- Reset release with DEPTH_WORDS = 16 → BusyM = 1 for exactly 16 cycles, then 0; lw at every word then returns 0.
- sw 0xDEADBEEF @0x10, then sb 0x55 @0x11 → lw @0x10 = 0xDEAD55EF; lb @0x13 = 0xFFFFFFDE; lbu @0x13 = 0x000000DE.
- sh 0x8001 @0x22 → lh @0x22 = 0xFFFF8001; lhu @0x22 = 0x00008001; lh @0x20 shows the lower half unchanged.
- sw @0x30 with KillM = 1 → following lw @0x30 returns the old value; ExcM = 0.
- Trap enabled, lw @0x0000_0006 → ExcM = 1, ExcCodeM = 4, BadVAddrM = 0x6. Trap enabled, sw @0x7 → ExcCodeM = 5 and memory is unchanged. Trap disabled, lw @0x6 → reads word 0x4, ExcM = 0.
- reset pulsed in CLEAR cycle 7 → count restarts; BusyM stays high for a full DEPTH_WORDS cycles after the new release.
